l2_line_responder: RTL and testbench
====================================

L2_LINE_RESPONDER -- requirements
Module: l2_line_responder

Interface
REQ-001 SHALL have parameter data_width, default 32, memory word width in bits.
REQ-002 SHALL have parameter address_width, default 32, byte address width.
REQ-003 SHALL have parameter block_size, default 32, words per cache line.
REQ-004 SHALL derive offset_width = clog2(data_width*block_size/8) and cache_width = block_size*data_width.
REQ-005 SHALL have port CLK, input, 1, the single clock; all state on rising edge.
REQ-006 SHALL have port RSTN, input, 1, reset; asynchronous, active-low.
REQ-007 SHALL have port ADDR_TO_L2_VALID, input, 1, single-cycle line-fill request pulse from I-cache.
REQ-008 SHALL have port ADDR_TO_L2, input, address_width-offset_width, line address.
REQ-009 SHALL have port DATA_FROM_L2, output, cache_width, assembled line; word k at bits [k*data_width +: data_width].
REQ-010 SHALL have port DATA_FROM_L2_VALID, output, 1, single-cycle line-ready pulse.
REQ-011 SHALL have port BUSY, output, 1, high in every state except IDLE.
REQ-012 SHALL have port MEM_REQ, output, 1, word read request valid.
REQ-013 SHALL have port MEM_REQ_READY, input, 1, memory accepts request when high with MEM_REQ.
REQ-014 SHALL have port MEM_ADDR, output, address_width, word byte address {line, word_idx, 2'b00}.
REQ-015 SHALL have port MEM_RDATA, input, data_width, read data, returned in request order.
REQ-016 SHALL have port MEM_RDATA_VALID, input, 1, MEM_RDATA valid this cycle.

Function
REQ-017 SHALL implement FSM IDLE -> ISSUE -> DRAIN -> RESPOND -> IDLE.
REQ-018 IDLE: on ADDR_TO_L2_VALID SHALL latch ADDR_TO_L2, clear both counters, go to ISSUE next cycle.
REQ-019 ADDR_TO_L2_VALID outside IDLE SHALL be ignored (no queueing); line address stays unchanged.
REQ-020 ISSUE: MEM_REQ SHALL be high; issue counter SHALL increment on each MEM_REQ & MEM_REQ_READY cycle; MEM_ADDR SHALL hold stable while not accepted.
REQ-021 After acceptance of word block_size-1, SHALL go to DRAIN and drop MEM_REQ in the next cycle.
REQ-022 Receive counter SHALL increment on each MEM_RDATA_VALID in ISSUE or DRAIN; data written to slot = receive counter; responses may overlap issuing.
REQ-023 When word block_size-1 is captured, next state SHALL be RESPOND, from ISSUE or DRAIN.
REQ-024 RESPOND: DATA_FROM_L2_VALID SHALL be high for exactly one cycle, then IDLE.
REQ-025 DATA_FROM_L2 SHALL hold the last complete line until the next line completes; partial fills never visible as a new line.
REQ-026 MEM_RDATA_VALID in IDLE or RESPOND SHALL be ignored.
REQ-027 Minimum latency with zero-wait memory returning data one cycle after acceptance: request at cycle 0, DATA_FROM_L2_VALID at cycle block_size+2.
REQ-028 Counters SHALL be clog2(block_size)+1 bits wide; no wrap within a fill.

Reset
REQ-029 RSTN low SHALL asynchronously force IDLE, counters 0, MEM_REQ 0, DATA_FROM_L2_VALID 0, BUSY 0, DATA_FROM_L2 0, MEM_ADDR 0.
REQ-030 Reset mid-fill SHALL abandon the fill; late memory responses after release SHALL be discarded per REQ-026.

Structure
REQ-031 FSM state enum and derived widths (offset_width, cache_width) SHALL live in shared package l2_pkg.
REQ-032 Line assembly register SHALL be sub-module line_assembler (write-enable, word index, word data in; line out).

Verification
REQ-033 Zero-wait memory, request line 0x000_0040 -> 32 reads at 0x2000..0x207C in order, DATA_FROM_L2_VALID at cycle 34, word k = pattern k.
REQ-034 MEM_REQ_READY low 3 cycles at word 5 -> MEM_ADDR held at 0x2014, MEM_REQ held high, line still correct.
REQ-035 Second ADDR_TO_L2_VALID during ISSUE -> ignored, exactly one response for first address.
REQ-036 RSTN low at word 10 -> all outputs 0 immediately; stray MEM_RDATA_VALID after release leaves DATA_FROM_L2 = 0.
REQ-037 Back-to-back fills, request in cycle after RESPOND -> second fill correct, DATA_FROM_L2 keeps line 1 until line 2 completes.
REQ-038 Memory latency 8 cycles -> FSM passes ISSUE->DRAIN->RESPOND, single valid pulse, BUSY low afterward.

Source files
------------

// File: rtl/l2_pkg.sv
// Shared FSM encoding and width helpers for the L2 line-fill responder.
// Widths depend on module parameters, so they are provided as constant functions.
package l2_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      DRAIN   = 2'd2,
      RESPOND = 2'd3
   } l2_state_t;

   localparam int DATA_WIDTH_DEFAULT    = 32;
   localparam int ADDRESS_WIDTH_DEFAULT = 32;
   localparam int BLOCK_SIZE_DEFAULT    = 32;

   function automatic int offset_width_f(input int data_width, input int block_size);
      return $clog2(data_width * block_size / 8);
   endfunction

   function automatic int cache_width_f(input int data_width, input int block_size);
      return data_width * block_size;
   endfunction

   // One extra bit lets a counter reach block_size without wrapping mid-fill.
   function automatic int counter_width_f(input int block_size);
      return $clog2(block_size) + 1;
   endfunction

   localparam int OFFSET_WIDTH = offset_width_f(DATA_WIDTH_DEFAULT, BLOCK_SIZE_DEFAULT);
   localparam int CACHE_WIDTH  = cache_width_f(DATA_WIDTH_DEFAULT, BLOCK_SIZE_DEFAULT);

endpackage

// File: rtl/l2_line_responder_if.sv
// Bundles the I-cache request/response pair and the word-read memory port.
// slave is the responder's view; master is the view of the I-cache plus memory.
interface l2_line_responder_if
   import l2_pkg::*;
#(
   parameter int data_width    = 32,
   parameter int address_width = 32,
   parameter int block_size    = 32
);
   localparam int offset_width = offset_width_f(data_width, block_size);
   localparam int cache_width  = cache_width_f(data_width, block_size);

   logic                                  ADDR_TO_L2_VALID;
   logic [address_width-offset_width-1:0] ADDR_TO_L2;
   logic [cache_width-1:0]                DATA_FROM_L2;
   logic                                  DATA_FROM_L2_VALID;
   logic                                  BUSY;
   logic                                  MEM_REQ;
   logic                                  MEM_REQ_READY;
   logic [address_width-1:0]              MEM_ADDR;
   logic [data_width-1:0]                 MEM_RDATA;
   logic                                  MEM_RDATA_VALID;

   modport slave (
      input  ADDR_TO_L2_VALID, ADDR_TO_L2, MEM_REQ_READY, MEM_RDATA, MEM_RDATA_VALID,
      output DATA_FROM_L2, DATA_FROM_L2_VALID, BUSY, MEM_REQ, MEM_ADDR
   );

   modport master (
      output ADDR_TO_L2_VALID, ADDR_TO_L2, MEM_REQ_READY, MEM_RDATA, MEM_RDATA_VALID,
      input  DATA_FROM_L2, DATA_FROM_L2_VALID, BUSY, MEM_REQ, MEM_ADDR
   );

endinterface

// File: rtl/l2_line_responder_line_assembler.sv
// Collects returned words into a fill buffer and publishes the whole line
// only when its last word arrives, so a partial fill is never observable.
module line_assembler
   import l2_pkg::*;
#(
   parameter int  data_width  = 32,
   parameter int  block_size  = 32,
   localparam int idx_width   = $clog2(block_size),
   localparam int cache_width = cache_width_f(data_width, block_size)
)
(
   input  logic                   CLK,
   input  logic                   RSTN,
   input  logic                   we,
   input  logic [idx_width-1:0]   word_idx,
   input  logic [data_width-1:0]  word_data,
   output logic [cache_width-1:0] line
);
   localparam logic [idx_width-1:0] LAST_IDX = idx_width'(block_size - 1);

   logic [cache_width-1:0] fill_buf;
   logic [cache_width-1:0] merged;

   always_comb begin
      merged = fill_buf;
      merged[int'(word_idx) * data_width +: data_width] = word_data;
   end

   // The published line takes the merged value so the final word lands in the same edge.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         fill_buf <= '0;
         line     <= '0;
      end else if (we) begin
         fill_buf <= merged;
         if (word_idx == LAST_IDX) begin
            line <= merged;
         end
      end
   end

endmodule

// File: rtl/l2_line_responder.sv
// Serves an I-cache line fill by issuing block_size word reads to memory,
// assembling the in-order returns, and pulsing DATA_FROM_L2_VALID when done.
module l2_line_responder
   import l2_pkg::*;
#(
   parameter int data_width    = 32,
   parameter int address_width = 32,
   parameter int block_size    = 32
)
(
   input logic                CLK,
   input logic                RSTN,
   l2_line_responder_if.slave bus
);
   localparam int offset_width = offset_width_f(data_width, block_size);
   localparam int idx_width    = $clog2(block_size);
   localparam int byte_width   = offset_width - idx_width;
   localparam int line_width   = address_width - offset_width;
   localparam int cnt_width    = counter_width_f(block_size);

   localparam logic [cnt_width-1:0] LAST_WORD = cnt_width'(block_size - 1);
   localparam logic [cnt_width-1:0] FULL_LINE = cnt_width'(block_size);

   l2_state_t             state;
   l2_state_t             next_state;
   logic [line_width-1:0] line_addr;
   logic [cnt_width-1:0]  issue_cnt;
   logic [cnt_width-1:0]  recv_cnt;
   logic                  start;
   logic                  issue_fire;
   logic                  capture;
   logic                  last_issue;
   logic                  last_capture;

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Returns may overlap issuing, so the final capture wins over the final accept.
   always_comb begin
      next_state             = state;
      start                  = 1'b0;
      issue_fire             = 1'b0;
      capture                = 1'b0;
      last_issue             = 1'b0;
      last_capture           = 1'b0;
      bus.MEM_REQ            = 1'b0;
      bus.BUSY               = 1'b1;
      bus.DATA_FROM_L2_VALID = 1'b0;
      case (state)
         IDLE: begin
            bus.BUSY = 1'b0;
            if (bus.ADDR_TO_L2_VALID) begin
               start      = 1'b1;
               next_state = ISSUE;
            end
         end
         ISSUE: begin
            bus.MEM_REQ  = (issue_cnt < FULL_LINE);
            issue_fire   = bus.MEM_REQ && bus.MEM_REQ_READY;
            last_issue   = issue_fire && (issue_cnt == LAST_WORD);
            capture      = bus.MEM_RDATA_VALID && (recv_cnt < FULL_LINE);
            last_capture = capture && (recv_cnt == LAST_WORD);
            if (last_capture) begin
               next_state = RESPOND;
            end else if (last_issue) begin
               next_state = DRAIN;
            end
         end
         DRAIN: begin
            capture      = bus.MEM_RDATA_VALID && (recv_cnt < FULL_LINE);
            last_capture = capture && (recv_cnt == LAST_WORD);
            if (last_capture) begin
               next_state = RESPOND;
            end
         end
         RESPOND: begin
            bus.DATA_FROM_L2_VALID = 1'b1;
            next_state             = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Line address is captured only on an accepted request, so requests mid-fill leave it alone.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         line_addr <= '0;
         issue_cnt <= '0;
         recv_cnt  <= '0;
      end else if (start) begin
         line_addr <= bus.ADDR_TO_L2;
         issue_cnt <= '0;
         recv_cnt  <= '0;
      end else begin
         if (issue_fire) begin
            issue_cnt <= issue_cnt + 1'b1;
         end
         if (capture) begin
            recv_cnt <= recv_cnt + 1'b1;
         end
      end
   end

   assign bus.MEM_ADDR = {line_addr, issue_cnt[idx_width-1:0], {byte_width{1'b0}}};

   line_assembler #(
      .data_width (data_width),
      .block_size (block_size)
   ) u_assembler (
      .CLK       (CLK),
      .RSTN      (RSTN),
      .we        (capture),
      .word_idx  (recv_cnt[idx_width-1:0]),
      .word_data (bus.MEM_RDATA),
      .line      (bus.DATA_FROM_L2)
   );

endmodule

// File: tb/tb_l2_line_responder.sv
// Self-checking bench: table of line fills plus hand-written corner sequences,
// with a memory model and a scoreboard of expected addresses and lines.
module tb_l2_line_responder;
   import l2_pkg::*;

   localparam int DW = 32;
   localparam int AW = 32;
   localparam int BS = 32;
   localparam int OW = offset_width_f(DW, BS);
   localparam int CW = cache_width_f(DW, BS);
   localparam int LW = AW - OW;

   typedef struct {
      logic [LW-1:0] line;
      int            latency;
      int            stall_word;
      int            stall_len;
      int            exp_lat;
   } fill_vec_t;

   typedef struct {
      logic [CW-1:0] line;
      int            req_cyc;
      int            exp_lat;
   } exp_line_t;

   typedef struct {
      logic [AW-1:0] addr;
      int            due;
   } pend_t;

   logic CLK;
   logic RSTN;

   l2_line_responder_if #(.data_width(DW), .address_width(AW), .block_size(BS)) bus();

   l2_line_responder #(.data_width(DW), .address_width(AW), .block_size(BS)) dut (
      .CLK  (CLK),
      .RSTN (RSTN),
      .bus  (bus)
   );

   int n_vec          = 0;
   int n_miss         = 0;
   int cyc            = 0;
   int done_count     = 0;
   int cfg_latency    = 1;
   int cfg_stall_word = -1;
   int cfg_stall_left = 0;

   logic [AW-1:0] exp_addr_q[$];
   exp_line_t     exp_line_q[$];
   pend_t         pend_q[$];
   fill_vec_t     vecs[5];

   function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
      return a ^ (a << 13) ^ 32'hA5C3_0F96;
   endfunction

   function automatic logic [CW-1:0] build_line(input logic [LW-1:0] l);
      logic [CW-1:0] r;
      r = '0;
      for (int k = 0; k < BS; k++) begin
         r[k*DW +: DW] = pat({l, 5'(k), 2'b00});
      end
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      n_vec++;
      if (actual !== expected) begin
         n_miss++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic checkLine(input string name, input logic [CW-1:0] actual, input logic [CW-1:0] expected);
      int bad;
      bad = -1;
      n_vec++;
      for (int k = BS - 1; k >= 0; k--) begin
         if (actual[k*DW +: DW] !== expected[k*DW +: DW]) bad = k;
      end
      if (bad >= 0) begin
         n_miss++;
         $display("[TB] FAIL %s: word %0d got 0x%08h, expected 0x%08h",
                  name, bad, actual[bad*DW +: DW], expected[bad*DW +: DW]);
      end
   endtask

   task automatic flagEvent(input string name, input string got, input string want);
      n_vec++;
      n_miss++;
      $display("[TB] FAIL %s: got %s, expected %s", name, got, want);
   endtask

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   always @(posedge CLK) cyc <= cyc + 1;

   // Memory model and line monitor, evaluated mid-cycle while DUT outputs are stable
   always @(negedge CLK) begin : mem_model
      logic      ready;
      pend_t     p;
      exp_line_t e;
      bus.MEM_RDATA_VALID = 1'b0;
      bus.MEM_RDATA       = '0;
      if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
         p                   = pend_q.pop_front();
         bus.MEM_RDATA_VALID = 1'b1;
         bus.MEM_RDATA       = pat(p.addr);
      end
      ready = 1'b1;
      if (bus.MEM_REQ && cfg_stall_left > 0 && int'(bus.MEM_ADDR[6:2]) == cfg_stall_word) begin
         ready = 1'b0;
         cfg_stall_left--;
         checkOutput("stall_addr_hold", bus.MEM_ADDR, (exp_addr_q.size() > 0) ? exp_addr_q[0] : {AW{1'b1}});
      end
      bus.MEM_REQ_READY = ready;
      if (bus.MEM_REQ && ready) begin
         if (exp_addr_q.size() == 0) flagEvent("mem_req", "request", "no request");
         else checkOutput("mem_addr", bus.MEM_ADDR, exp_addr_q.pop_front());
         p.addr = bus.MEM_ADDR;
         p.due  = cyc + cfg_latency;
         pend_q.push_back(p);
      end
      if (bus.DATA_FROM_L2_VALID) begin
         done_count++;
         if (exp_line_q.size() == 0) flagEvent("line_valid", "pulse", "no pulse");
         else begin
            e = exp_line_q.pop_front();
            checkLine("line_data", bus.DATA_FROM_L2, e.line);
            checkOutput("line_latency", cyc - e.req_cyc, e.exp_lat);
         end
      end
   end

   task automatic applyStimulus(input logic [LW-1:0] line, input int latency, input int stall_word,
                                input int stall_len, input int exp_lat);
      exp_line_t e;
      cfg_latency    = latency;
      cfg_stall_word = stall_word;
      cfg_stall_left = stall_len;
      for (int k = 0; k < BS; k++) exp_addr_q.push_back({line, 5'(k), 2'b00});
      e.line    = build_line(line);
      e.req_cyc = cyc;
      e.exp_lat = exp_lat;
      exp_line_q.push_back(e);
      bus.ADDR_TO_L2       = line;
      bus.ADDR_TO_L2_VALID = 1'b1;
      @(negedge CLK);
      bus.ADDR_TO_L2_VALID = 1'b0;
   endtask

   task automatic waitDone(input int target, input string name);
      int t;
      t = 0;
      while (done_count < target && t < 300) begin
         @(posedge CLK);
         t++;
      end
      if (done_count < target) flagEvent(name, "timeout", "line response");
   endtask

   initial begin : main
      int base;
      int t;
      RSTN                 = 1'b0;
      bus.ADDR_TO_L2_VALID = 1'b0;
      bus.ADDR_TO_L2       = '0;
      vecs[0] = '{line: 25'h40,      latency: 1, stall_word: -1, stall_len: 0, exp_lat: 34};
      vecs[1] = '{line: 25'h40,      latency: 1, stall_word: 5,  stall_len: 3, exp_lat: 37};
      vecs[2] = '{line: 25'h1ABCD,   latency: 8, stall_word: -1, stall_len: 0, exp_lat: 41};
      vecs[3] = '{line: 25'h1FFFFFF, latency: 2, stall_word: 31, stall_len: 2, exp_lat: 37};
      vecs[4] = '{line: 25'h0,       latency: 3, stall_word: 0,  stall_len: 1, exp_lat: 37};

      repeat (3) @(negedge CLK);
      checkOutput("rst_busy", bus.BUSY, 0);
      checkOutput("rst_mem_req", bus.MEM_REQ, 0);
      checkOutput("rst_valid", bus.DATA_FROM_L2_VALID, 0);
      checkOutput("rst_mem_addr", bus.MEM_ADDR, 0);
      checkLine("rst_line", bus.DATA_FROM_L2, '0);
      RSTN = 1'b1;

      for (int i = 0; i < 5; i++) begin
         base = done_count;
         @(negedge CLK);
         applyStimulus(vecs[i].line, vecs[i].latency, vecs[i].stall_word, vecs[i].stall_len, vecs[i].exp_lat);
         waitDone(base + 1, "fill_done");
         @(negedge CLK);
         checkOutput("busy_after", bus.BUSY, 0);
         checkOutput("valid_after", bus.DATA_FROM_L2_VALID, 0);
         checkLine("line_held", bus.DATA_FROM_L2, build_line(vecs[i].line));
      end

      // A second request mid-fill must be dropped without disturbing the first
      base = done_count;
      @(negedge CLK);
      applyStimulus(25'h55, 1, -1, 0, 34);
      repeat (4) @(negedge CLK);
      bus.ADDR_TO_L2       = 25'h77;
      bus.ADDR_TO_L2_VALID = 1'b1;
      @(negedge CLK);
      bus.ADDR_TO_L2_VALID = 1'b0;
      bus.ADDR_TO_L2       = '0;
      waitDone(base + 1, "ignored_req_done");
      repeat (40) @(negedge CLK);
      checkOutput("single_response", done_count - base, 1);
      checkOutput("busy_idle", bus.BUSY, 0);

      // Back-to-back fills: next request lands in the cycle after RESPOND
      base = done_count;
      @(negedge CLK);
      applyStimulus(25'h3C, 1, -1, 0, 34);
      t = 0;
      while (!bus.DATA_FROM_L2_VALID && t < 100) begin
         @(negedge CLK);
         t++;
      end
      if (!bus.DATA_FROM_L2_VALID) flagEvent("b2b_first", "timeout", "line response");
      @(negedge CLK);
      applyStimulus(25'h1234, 1, -1, 0, 34);
      repeat (18) @(negedge CLK);
      checkLine("line1_hold", bus.DATA_FROM_L2, build_line(25'h3C));
      checkOutput("busy_fill2", bus.BUSY, 1);
      waitDone(base + 2, "b2b_second");
      @(negedge CLK);
      checkLine("line2_final", bus.DATA_FROM_L2, build_line(25'h1234));

      // Reset mid-fill, with responses still in flight when reset releases
      @(negedge CLK);
      applyStimulus(25'h123, 6, -1, 0, 39);
      t = 0;
      while (!(bus.MEM_REQ && bus.MEM_ADDR[6:2] == 5'd10) && t < 100) begin
         @(negedge CLK);
         t++;
      end
      if (!bus.MEM_REQ) flagEvent("reach_word10", "timeout", "request of word 10");
      #2 RSTN = 1'b0;
      #1;
      checkOutput("async_mem_req", bus.MEM_REQ, 0);
      checkOutput("async_busy", bus.BUSY, 0);
      checkOutput("async_valid", bus.DATA_FROM_L2_VALID, 0);
      checkOutput("async_mem_addr", bus.MEM_ADDR, 0);
      checkLine("async_line", bus.DATA_FROM_L2, '0);
      exp_addr_q.delete();
      exp_line_q.delete();
      @(negedge CLK);
      RSTN = 1'b1;
      repeat (12) @(negedge CLK);
      checkLine("line_after_stray", bus.DATA_FROM_L2, '0);
      checkOutput("busy_after_stray", bus.BUSY, 0);

      base = done_count;
      @(negedge CLK);
      applyStimulus(25'h2, 1, -1, 0, 34);
      waitDone(base + 1, "recovery_done");
      @(negedge CLK);
      checkLine("recovery_line", bus.DATA_FROM_L2, build_line(25'h2));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got simulation still running, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
